fifo_word_packer: RTL and testbench
===================================

Name: fifo_word_packer

Overview:
- Downstream consumer of the afifo read port, clocked in the read domain (clk).
- Pops bytes from the FIFO whenever it is non-empty and packs them into 32-bit words (default), little-endian.
- Presents each word on a valid/ready output port.
- Flushes a partial word with a byte-keep mask after an idle timeout, so trailing bytes are never stranded.

Parameters:
- DW, 8, FIFO data width in bits (one "byte").
- BYTES, 4, bytes per output word.
- TIMEOUT, 16, idle cycles before a partial word is flushed; 0 disables flushing.

Ports:
- clk  in  1  read-domain clock; the only clock in this block.
- rst  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  afifo empty flag.
- fifo_read  out  1  afifo read strobe; one byte popped per cycle high.
- fifo_rdata  in  DW  afifo read data; valid in the cycle after fifo_read.
- out_data  out  DW*BYTES  packed word; byte 0 in bits [DW-1:0].
- out_keep  out  BYTES  bit i high = byte i of out_data is valid.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready at a rising clk edge.

Behaviour:
- Reset (rst low, asynchronous):
  - out_valid=0, out_data=0, out_keep=0.
  - Byte count=0, in-flight flag=0, timeout counter=0.
  - fifo_read is forced 0 while rst is low.
- Read latency: fifo_read high in cycle t -> fifo_rdata sampled at the end of cycle t+1 and written into assembly slot `count`.
- Read issue: fifo_read = !fifo_empty && (count + inflight) < BYTES && !stall.
  - inflight = 1 when a read was issued in the previous cycle and its byte is not yet captured.
  - The block never over-reads. At most one read is in flight; back-to-back reads are allowed, giving one byte per cycle sustained.
  - stall = assembly is full, or the final slot is in flight, while the output register is occupied and out_ready=0.
- Word completion:
  - When the byte filling slot BYTES-1 is captured and the output register is free (out_valid=0, or out_valid && out_ready this cycle), the full assembly including that byte loads into out_data with out_keep = all ones.
  - In the same edge, count returns to 0.
  - Otherwise the assembly holds full and no reads issue until the load happens.
- Latency: BYTES bytes already in the FIFO, first read at cycle t0 -> out_valid high in cycle t0+BYTES+1.
- Output handshake:
  - out_data, out_keep and out_valid are stable while out_valid && !out_ready.
  - out_valid drops after acceptance unless a new word loads in the same edge (back-to-back words are allowed).
- Timeout flush:
  - The counter increments each cycle in which count>0, inflight=0 and fifo_empty=1.
  - The counter clears on any byte capture or flush.
  - When counter==TIMEOUT and the output register is free:
    - load the partial word, with unused bytes zero;
    - out_keep = (1<<count)-1;
    - count=0.
  - If the output register is busy at that point, the flush waits; the counter saturates at TIMEOUT.
  - TIMEOUT=0: never flush; partial bytes wait for more data.
- Simultaneous events:
  - Capture and flush cannot coincide: a flush requires inflight=0.
  - Acceptance and load in the same edge: the new word replaces the old one and out_valid stays 1.
- fifo_empty toggling mid-word: reads pause and resume; byte order is preserved.
- Reset mid-operation: partial assembly and any in-flight byte are discarded (that byte is already popped from the FIFO and is lost); the output word is dropped.

Test Plan:
- FIFO holds 0x01..0x04, out_ready=1 -> fifo_read high 4 consecutive cycles; one word: out_data=0x04030201, out_keep=4'b1111, out_valid high 1 cycle at t0+5.
- FIFO holds 0x01..0x08, out_ready=0 for 10 cycles then 1:
  - word 0x04030201 is held stable;
  - bytes 5-8 are read and assembled, then reads stop;
  - on accept, 0x08070605 follows on the next cycle.
- FIFO holds 0x0A,0x0B then stays empty, TIMEOUT=16 -> 16 idle cycles after the last capture, out_data=0x00000B0A, out_keep=4'b0011; with TIMEOUT=0, no output ever.
- fifo_empty alternates every other cycle while 0x11..0x14 arrive -> reads only when non-empty; out_data=0x14131211; never more than one read in flight.
- rst pulsed low with 2 bytes assembled and 1 in flight -> all outputs 0 immediately (asynchronous); the next 4 FIFO bytes 0x21..0x24 produce exactly 0x24232221.

Source files
------------

// File: rtl/fifo_word_packer_if.sv
// Handshake bundle for the word packer: afifo read port on one side,
// valid/ready word stream on the other.
interface fifo_word_packer_if #(
    parameter int DW    = 8,
    parameter int BYTES = 4
);
    logic                  fifo_empty;
    logic                  fifo_read;
    logic [DW-1:0]         fifo_rdata;
    logic [DW*BYTES-1:0]   out_data;
    logic [BYTES-1:0]      out_keep;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  fifo_empty, fifo_rdata, out_ready,
        output fifo_read, out_data, out_keep, out_valid
    );

    modport slave (
        output fifo_empty, fifo_rdata, out_ready,
        input  fifo_read, out_data, out_keep, out_valid
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops bytes from the afifo read port and packs them little-endian into
// words; a partial word is flushed with a keep mask after an idle timeout.
module fifo_word_packer #(
    parameter int DW      = 8,
    parameter int BYTES   = 4,
    parameter int TIMEOUT = 16
) (
    input logic                clk,
    input logic                rst,
    fifo_word_packer_if.master bus
);
    localparam int CW = $clog2(BYTES + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] FULL = CW'(BYTES);
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
    localparam logic [CW:0]   LIM  = (CW+1)'(BYTES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [CW-1:0]            count;
    logic                     inflight;
    logic [TW-1:0]            tcnt;
    logic [BYTES-1:0][DW-1:0] slots;
    logic [BYTES-1:0][DW-1:0] word_d;
    logic [BYTES-1:0]         keep_d;
    logic [CW:0]              pending;
    logic out_free, capture, full, last_cap, stall, idle, flush, load_full, load;

    always_comb begin
        out_free  = !bus.out_valid || bus.out_ready;
        capture   = inflight;
        full      = (count == FULL);
        last_cap  = capture && (count == LAST);
        stall     = (full || last_cap) && bus.out_valid && !bus.out_ready;
        pending   = {1'b0, count} + {{CW{1'b0}}, inflight};
        idle      = (count != '0) && !inflight && bus.fifo_empty;
        load_full = (full || last_cap) && out_free;
        // A flush needs no byte in flight, so it can never race a capture.
        flush     = (TIMEOUT != 0) && (tcnt == TMAX) && (count != '0) &&
                    !inflight && !full && out_free;
        load      = load_full || flush;
        bus.fifo_read = rst && !bus.fifo_empty && (pending < LIM) && !stall;
    end

    // Unused slots of a partial word go out as zero, not stale data.
    always_comb begin
        word_d = '0;
        keep_d = '0;
        for (int i = 0; i < BYTES; i++) begin
            keep_d[i] = load_full || (count > CW'(i));
            word_d[i] = keep_d[i] ? slots[i] : '0;
        end
        if (last_cap) word_d[BYTES-1] = bus.fifo_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            inflight <= 1'b0;
            tcnt     <= '0;
            slots    <= '0;
        end else begin
            inflight <= bus.fifo_read;
            for (int i = 0; i < BYTES; i++)
                if (capture && count == CW'(i)) slots[i] <= bus.fifo_rdata;
            if (load)         count <= '0;
            else if (capture) count <= count + 1'b1;
            if (capture || load)              tcnt <= '0;
            else if (idle && tcnt != TMAX)    tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_keep  <= '0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= word_d;
            bus.out_keep  <= keep_d;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-backed afifo model, word scoreboard and
// directed plus randomized scenarios.
module tb_fifo_word_packer;
    localparam int DW      = 8;
    localparam int BYTES   = 4;
    localparam int TIMEOUT = 16;
    localparam int WW      = DW * BYTES + BYTES;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_word_packer_if #(.DW(DW), .BYTES(BYTES)) bus ();
    fifo_word_packer_if #(.DW(DW), .BYTES(BYTES)) bus0 ();

    fifo_word_packer #(.DW(DW), .BYTES(BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    fifo_word_packer #(.DW(DW), .BYTES(BYTES), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] q[$];
    logic          gate_empty = 1'b0;
    logic [WW-1:0] got[$];
    int reads, valid_cycles, first_read, last_read, first_valid;
    logic          hold_prev = 1'b0;
    logic [DW*BYTES-1:0] prev_data;
    logic [BYTES-1:0]    prev_keep;

    always @(posedge clk) cyc <= cyc + 1;

    // afifo model plus output monitor; samples one time unit before each rising edge
    initial begin : fifo_model
        logic pop_pend;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = '0;
        forever begin
            @(negedge clk); #4;
            pop_pend = bus.fifo_read;
            if (bus.fifo_read) begin
                total++;
                if (bus.fifo_empty !== 1'b0 || q.size() == 0) begin
                    bad++;
                    $display("FAIL overread: fifo_read=1 with fifo_empty=%b depth=%0d", bus.fifo_empty, q.size());
                end
            end
            if (rst) begin
                if (bus.fifo_read) begin
                    reads++;
                    if (first_read < 0) first_read = cyc;
                    last_read = cyc;
                end
                if (bus.out_valid) begin
                    valid_cycles++;
                    if (first_valid < 0) first_valid = cyc;
                end
                if (hold_prev) begin
                    total++;
                    if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_keep !== prev_keep) begin
                        bad++;
                        $display("FAIL hold_stable: got v=%b d=%h k=%b want v=1 d=%h k=%b",
                                 bus.out_valid, bus.out_data, bus.out_keep, prev_data, prev_keep);
                    end
                end
                if (bus.out_valid && bus.out_ready) got.push_back({bus.out_keep, bus.out_data});
                hold_prev = bus.out_valid && !bus.out_ready;
                prev_data = bus.out_data;
                prev_keep = bus.out_keep;
            end else begin
                hold_prev = 1'b0;
            end
            @(posedge clk); #1;
            if (pop_pend && q.size() > 0) bus.fifo_rdata = q.pop_front();
            bus.fifo_empty = (q.size() == 0) || gate_empty;
        end
    end

    task automatic clear_mon();
        reads = 0; valid_cycles = 0; first_read = -1; last_read = -1; first_valid = -1;
        got.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #4;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
        total++; if (bus.out_keep !== '0) begin bad++; $display("FAIL reset_keep: got %b want 0", bus.out_keep); end
        total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("FAIL reset_read: got %b want 0", bus.fifo_read); end
        total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid0: got %b want 0", bus0.out_valid); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        clear_mon();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) q.push_back(DW'(i));
        repeat (15) @(negedge clk);
        #4;
        total++; if (reads != 4) begin bad++; $display("FAIL single_reads: got %0d want 4", reads); end
        total++; if (last_read - first_read != 3) begin bad++; $display("FAIL single_b2b: got span %0d want 3", last_read - first_read); end
        total++; if (first_valid - first_read != 5) begin bad++; $display("FAIL single_latency: got %0d want 5", first_valid - first_read); end
        total++; if (valid_cycles != 1) begin bad++; $display("FAIL single_valid_len: got %0d want 1", valid_cycles); end
        total++;
        if (got.size() != 1 || got[0] !== {4'hF, 32'h04030201}) begin
            bad++; $display("FAIL single_word: got n=%0d w=%h want n=1 w=%h", got.size(), (got.size() > 0) ? got[0] : '0, {4'hF, 32'h04030201});
        end
    endtask

    task automatic test_backpressure();
        clear_mon();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) q.push_back(DW'(i));
        repeat (14) @(negedge clk);
        #4;
        total++; if (reads != 8) begin bad++; $display("FAIL bp_reads: got %0d want 8", reads); end
        total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("FAIL bp_stalled: got %b want 0", bus.fifo_read); end
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h04030201 || bus.out_keep !== 4'hF) begin
            bad++; $display("FAIL bp_held: got v=%b d=%h want v=1 d=04030201", bus.out_valid, bus.out_data);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk); #4;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h08070605 || bus.out_keep !== 4'hF) begin
            bad++; $display("FAIL bp_next: got v=%b d=%h want v=1 d=08070605", bus.out_valid, bus.out_data);
        end
        repeat (3) @(negedge clk);
        #4;
        total++;
        if (got.size() != 2 || got[1] !== {4'hF, 32'h08070605}) begin
            bad++; $display("FAIL bp_words: got n=%0d want 2", got.size());
        end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_timeout();
        clear_mon();
        bus.out_ready = 1'b1;
        q.push_back(8'h0A);
        q.push_back(8'h0B);
        repeat (30) @(negedge clk);
        #4;
        total++; if (reads != 2) begin bad++; $display("FAIL to_reads: got %0d want 2", reads); end
        // last byte captured one cycle after its read, then TIMEOUT idle cycles, then the flush edge
        total++;
        if (first_valid - last_read != TIMEOUT + 3) begin
            bad++; $display("FAIL to_latency: got %0d want %0d", first_valid - last_read, TIMEOUT + 3);
        end
        total++;
        if (got.size() != 1 || got[0] !== {4'b0011, 32'h00000B0A}) begin
            bad++; $display("FAIL to_word: got n=%0d w=%h want %h", got.size(), (got.size() > 0) ? got[0] : '0, {4'b0011, 32'h00000B0A});
        end
        total++; if (valid_cycles != 1) begin bad++; $display("FAIL to_valid_len: got %0d want 1", valid_cycles); end
    endtask

    task automatic test_timeout_zero();
        logic [DW-1:0] b[2];
        int k = 0;
        int nv = 0;
        logic rd;
        b[0] = 8'h0A;
        b[1] = 8'h0B;
        @(posedge clk); #1;
        bus0.fifo_empty = 1'b0;
        repeat (60) begin
            @(negedge clk); #4;
            rd = bus0.fifo_read;
            if (bus0.out_valid) nv++;
            @(posedge clk); #1;
            if (rd) begin
                if (k < 2) bus0.fifo_rdata = b[k];
                k++;
                if (k >= 2) bus0.fifo_empty = 1'b1;
            end
        end
        total++; if (k != 2) begin bad++; $display("FAIL to0_reads: got %0d want 2", k); end
        total++; if (nv != 0) begin bad++; $display("FAIL to0_no_output: got %0d valid cycles want 0", nv); end
    endtask

    task automatic test_empty_toggle();
        clear_mon();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) q.push_back(8'h11 + DW'(i));
        repeat (12) begin
            @(negedge clk);
            gate_empty = ~gate_empty;
        end
        gate_empty = 1'b0;
        repeat (8) @(negedge clk);
        #4;
        total++; if (reads != 4) begin bad++; $display("FAIL tog_reads: got %0d want 4", reads); end
        total++; if (last_read - first_read != 6) begin bad++; $display("FAIL tog_spacing: got span %0d want 6", last_read - first_read); end
        total++;
        if (got.size() != 1 || got[0] !== {4'hF, 32'h14131211}) begin
            bad++; $display("FAIL tog_word: got n=%0d w=%h want %h", got.size(), (got.size() > 0) ? got[0] : '0, {4'hF, 32'h14131211});
        end
    endtask

    task automatic test_reset_midop();
        int n = 0;
        int seen = 0;
        clear_mon();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) q.push_back(8'h41 + DW'(i));
        while (bus.out_valid !== 1'b1 && n < 30) begin @(negedge clk); #4; n++; end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %b want 1", bus.out_valid); end
        for (int i = 0; i < 3; i++) q.push_back(8'h31 + DW'(i));
        n = 0;
        while (seen < 3 && n < 30) begin @(negedge clk); #4; if (bus.fifo_read) seen++; n++; end
        total++; if (seen != 3) begin bad++; $display("FAIL rst_pre_reads: got %0d want 3", seen); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_keep !== '0 || bus.fifo_read !== 1'b0) begin
            bad++; $display("FAIL rst_async: got v=%b d=%h k=%b r=%b want all 0",
                            bus.out_valid, bus.out_data, bus.out_keep, bus.fifo_read);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_mon();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) q.push_back(8'h21 + DW'(i));
        repeat (15) @(negedge clk);
        #4;
        total++; if (reads != 4) begin bad++; $display("FAIL rst_post_reads: got %0d want 4", reads); end
        total++;
        if (got.size() != 1 || got[0] !== {4'hF, 32'h24232221}) begin
            bad++; $display("FAIL rst_post_word: got n=%0d w=%h want %h", got.size(), (got.size() > 0) ? got[0] : '0, {4'hF, 32'h24232221});
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] bytes[$];
        logic [WW-1:0] exp[$];
        logic [DW*BYTES-1:0] w;
        logic [BYTES-1:0] kp;
        logic [DW-1:0] b;
        int n, k, run;
        clear_mon();
        n = $urandom_range(37, 47);
        for (int i = 0; i < n; i++) begin
            b = DW'($urandom_range(0, 255));
            bytes.push_back(b);
            q.push_back(b);
        end
        // reference: bytes chunked into little-endian words, last chunk padded and masked
        for (int i = 0; i < n; i += BYTES) begin
            w = '0; kp = '0;
            for (int j = 0; j < BYTES; j++)
                if (i + j < n) begin w[j*DW +: DW] = bytes[i+j]; kp[j] = 1'b1; end
            exp.push_back({kp, w});
        end
        k = 0; run = 0;
        while (got.size() < exp.size() && k < 3000) begin
            @(negedge clk);
            gate_empty = (run < 5) && ($urandom_range(0, 3) == 0);
            run = gate_empty ? run + 1 : 0;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            k++;
        end
        gate_empty = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #4;
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp.size()); end
        total++; if (reads != n) begin bad++; $display("FAIL rand_reads: got %0d want %0d", reads, n); end
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                bad++; $display("FAIL rand_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : '0, exp[i]);
            end
        end
    endtask

    initial begin
        bus.out_ready   = 1'b0;
        bus0.fifo_empty = 1'b1;
        bus0.fifo_rdata = '0;
        bus0.out_ready  = 1'b1;
        clear_mon();
        test_reset();
        test_single_word();
        test_backpressure();
        test_timeout();
        test_timeout_zero();
        test_empty_toggle();
        test_reset_midop();
        test_random();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: got no finish want finish before limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
